ddr_app_arbiter: RTL and testbench

DDR_APP_ARBITER -- requirements
Module: ddr_app_arbiter

---
 rtl/ddr_arb_pkg.sv | 19 +
 rtl/ddr_app_arbiter_rr_arb2.sv | 39 +++
 rtl/ddr_app_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ddr_app_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the two-port MIG application-interface arbiter.
package ddr_arb_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_RD_CMD  = 3'd2,
      S_RD_WAIT = 3'd3,
      S_RESP    = 3'd4
   } state_t;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   localparam int DEF_APP_DATA_WIDTH = 128;
   localparam int DEF_APP_MASK_WIDTH = 16;
   localparam int WORD_WIDTH         = 32;

endpackage

// File: rtl/ddr_app_arbiter_rr_arb2.sv
// Two-port round-robin grant: a lone request wins, a tie goes to the port
// that was not granted last. The last-grant register starts at port 1 so
// port 0 wins the first tie after reset.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_q;
   logic last_d;

   // Combinational one-hot grant and last-grant update on an accepted grant
   always_comb begin
      grant  = 2'b00;
      last_d = last_q;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
      if (advance && (grant != 2'b00)) begin
         last_d = grant[1];
      end
   end

   // Last-grant register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/ddr_app_arbiter.sv
// Arbitrates two single-word requesters onto one MIG UI port. Writes are
// turned into a full-line write with the word replicated and all other bytes
// masked; reads fetch a line and return the addressed 32-bit word.
module ddr_app_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 28,
   parameter int APP_DATA_WIDTH = DEF_APP_DATA_WIDTH,
   parameter int APP_MASK_WIDTH = DEF_APP_MASK_WIDTH
) (
   input  logic                      clk,
   input  logic                      sys_rst_n,
   input  logic                      init_calib_complete,
   input  logic                      req0,
   input  logic                      req1,
   input  logic                      we0,
   input  logic                      we1,
   input  logic [ADDR_WIDTH-1:0]     addr0,
   input  logic [ADDR_WIDTH-1:0]     addr1,
   input  logic [WORD_WIDTH-1:0]     wdata0,
   input  logic [WORD_WIDTH-1:0]     wdata1,
   output logic                      ack0,
   output logic                      ack1,
   output logic [WORD_WIDTH-1:0]     rdata,
   output logic [ADDR_WIDTH-1:0]     app_addr,
   output logic [2:0]                app_cmd,
   output logic                      app_en,
   input  logic                      app_rdy,
   output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
   output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
   output logic                      app_wdf_wren,
   output logic                      app_wdf_end,
   input  logic                      app_wdf_rdy,
   input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
   input  logic                      app_rd_data_valid,
   input  logic                      app_rd_data_end
);

   state_t                    state_q, state_d;
   logic                      gnt_q, gnt_d;
   logic [1:0]                off_q, off_d;
   logic [ADDR_WIDTH-1:0]     app_addr_q, app_addr_d;
   logic [2:0]                app_cmd_q, app_cmd_d;
   logic                      app_en_q, app_en_d;
   logic                      wren_q, wren_d;
   logic [APP_DATA_WIDTH-1:0] wdf_data_q, wdf_data_d;
   logic [APP_MASK_WIDTH-1:0] mask_q, mask_d;
   logic                      ack0_q, ack0_d;
   logic                      ack1_q, ack1_d;
   logic [WORD_WIDTH-1:0]     rdata_q, rdata_d;

   logic [1:0]                grant;
   logic                      advance;
   logic                      sel_port;
   logic                      sel_we;
   logic [ADDR_WIDTH-1:0]     sel_addr;
   logic [WORD_WIDTH-1:0]     sel_wdata;
   logic                      unused_ok;

   // Enable only the four bytes of the addressed word within the line
   function automatic logic [APP_MASK_WIDTH-1:0] wr_mask(input logic [1:0] off);
      logic [APP_MASK_WIDTH-1:0] m;
      m = '1;
      m[{off, 2'b00} +: 4] = 4'h0;
      return m;
   endfunction

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .rst_n   (sys_rst_n),
      .req     ({req1, req0}),
      .advance (advance),
      .grant   (grant)
   );

   assign sel_port  = grant[1];
   assign sel_we    = sel_port ? we1    : we0;
   assign sel_addr  = sel_port ? addr1  : addr0;
   assign sel_wdata = sel_port ? wdata1 : wdata0;

   // Byte-offset bits and the end-of-burst flag carry no information here
   assign unused_ok = ^{app_rd_data_end, sel_addr[1:0]};

   // Next-state and registered-output logic for the transaction FSM
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      off_d      = off_q;
      app_addr_d = app_addr_q;
      app_cmd_d  = app_cmd_q;
      app_en_d   = app_en_q;
      wren_d     = wren_q;
      wdf_data_d = wdf_data_q;
      mask_d     = mask_q;
      rdata_d    = rdata_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      advance    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (init_calib_complete && (req0 || req1)) begin
               advance    = 1'b1;
               gnt_d      = sel_port;
               off_d      = sel_addr[3:2];
               app_addr_d = {1'b0, sel_addr[ADDR_WIDTH-1:4], 3'b000};
               app_en_d   = 1'b1;
               if (sel_we) begin
                  app_cmd_d  = CMD_WRITE;
                  wren_d     = 1'b1;
                  wdf_data_d = {(APP_DATA_WIDTH/WORD_WIDTH){sel_wdata}};
                  mask_d     = wr_mask(sel_addr[3:2]);
                  state_d    = S_WR;
               end else begin
                  app_cmd_d  = CMD_READ;
                  state_d    = S_RD_CMD;
               end
            end
         end
         S_WR: begin
            // Command and data handshakes retire independently
            if (app_rdy)     app_en_d = 1'b0;
            if (app_wdf_rdy) wren_d   = 1'b0;
            if ((!app_en_q || app_rdy) && (!wren_q || app_wdf_rdy)) begin
               state_d = S_RESP;
               ack0_d  = ~gnt_q;
               ack1_d  = gnt_q;
            end
         end
         S_RD_CMD: begin
            if (app_rdy) begin
               app_en_d = 1'b0;
               state_d  = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (app_rd_data_valid) begin
               rdata_d = app_rd_data[{off_q, 5'b00000} +: WORD_WIDTH];
               state_d = S_RESP;
               ack0_d  = ~gnt_q;
               ack1_d  = gnt_q;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= S_IDLE;
         gnt_q      <= 1'b0;
         off_q      <= 2'b00;
         app_addr_q <= '0;
         app_cmd_q  <= CMD_WRITE;
         app_en_q   <= 1'b0;
         wren_q     <= 1'b0;
         wdf_data_q <= '0;
         mask_q     <= '1;
         rdata_q    <= '0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         off_q      <= off_d;
         app_addr_q <= app_addr_d;
         app_cmd_q  <= app_cmd_d;
         app_en_q   <= app_en_d;
         wren_q     <= wren_d;
         wdf_data_q <= wdf_data_d;
         mask_q     <= mask_d;
         rdata_q    <= rdata_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
      end
   end

   assign app_addr     = app_addr_q;
   assign app_cmd      = app_cmd_q;
   assign app_en       = app_en_q;
   assign app_wdf_data = wdf_data_q;
   assign app_wdf_mask = mask_q;
   assign app_wdf_wren = wren_q;
   assign app_wdf_end  = wren_q;
   assign rdata        = rdata_q;
   assign ack0         = ack0_q;
   assign ack1         = ack1_q;

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// Scoreboard bench for ddr_app_arbiter: directed requests push expected
// commands, write lines and acks; a negedge monitor pops and compares them.
module tb_ddr_app_arbiter;

   localparam int AW = 28;
   localparam int DW = 128;
   localparam int MW = 16;

   logic          clk = 1'b0;
   logic          sys_rst_n;
   logic          init_calib_complete;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [31:0]   wdata0, wdata1;
   logic          ack0, ack1;
   logic [31:0]   rdata;
   logic [AW-1:0] app_addr;
   logic [2:0]    app_cmd;
   logic          app_en, app_rdy;
   logic [DW-1:0] app_wdf_data;
   logic [MW-1:0] app_wdf_mask;
   logic          app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [DW-1:0] app_rd_data;
   logic          app_rd_data_valid;

   logic          resp_valid;
   logic          stale_valid;
   logic          resp_en;
   logic [DW-1:0] rd_line;

   int            errors = 0;
   int            checks = 0;

   logic [30:0]   cmd_q[$];   // {app_addr, app_cmd}
   logic [143:0]  wdf_q[$];   // {app_wdf_data, app_wdf_mask}
   logic [33:0]   ack_q[$];   // {is_read, port, rdata}

   always #5 clk = ~clk;

   assign app_rd_data_valid = resp_valid | stale_valid;
   assign app_rd_data       = app_rd_data_valid ? rd_line : '0;

   ddr_app_arbiter #(.ADDR_WIDTH(AW), .APP_DATA_WIDTH(DW), .APP_MASK_WIDTH(MW)) dut (
      .clk                 (clk),
      .sys_rst_n           (sys_rst_n),
      .init_calib_complete (init_calib_complete),
      .req0                (req0),
      .req1                (req1),
      .we0                 (we0),
      .we1                 (we1),
      .addr0               (addr0),
      .addr1               (addr1),
      .wdata0              (wdata0),
      .wdata1              (wdata1),
      .ack0                (ack0),
      .ack1                (ack1),
      .rdata               (rdata),
      .app_addr            (app_addr),
      .app_cmd             (app_cmd),
      .app_en              (app_en),
      .app_rdy             (app_rdy),
      .app_wdf_data        (app_wdf_data),
      .app_wdf_mask        (app_wdf_mask),
      .app_wdf_wren        (app_wdf_wren),
      .app_wdf_end         (app_wdf_end),
      .app_wdf_rdy         (app_wdf_rdy),
      .app_rd_data         (app_rd_data),
      .app_rd_data_valid   (app_rd_data_valid),
      .app_rd_data_end     (app_rd_data_valid)
   );

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: actual=no-event required=event-within-bound", name);
   endtask

   task automatic exp_wr(input bit port, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [MW-1:0] m);
      cmd_q.push_back({a, 3'b000});
      wdf_q.push_back({{4{d}}, m});
      ack_q.push_back({1'b0, port, 32'h0});
   endtask

   task automatic exp_rd(input bit port, input logic [AW-1:0] a, input logic [31:0] d);
      cmd_q.push_back({a, 3'b001});
      ack_q.push_back({1'b1, port, d});
   endtask

   // Raise a request, wait for its ack, drop it on the edge after the ack
   task automatic request(input bit port, input logic we, input logic [AW-1:0] a,
                          input logic [31:0] wd, output int lat);
      @(posedge clk); #1;
      if (port) begin we1 = we; addr1 = a; wdata1 = wd; req1 = 1'b1; end
      else      begin we0 = we; addr0 = a; wdata0 = wd; req0 = 1'b1; end
      lat = 0;
      while (1) begin
         @(negedge clk);
         lat++;
         if ((port ? ack1 : ack0) === 1'b1) break;
         if (lat >= 300) begin
            fail(port ? "ack1_timeout" : "ack0_timeout");
            break;
         end
      end
      @(posedge clk); #1;
      if (port) req1 = 1'b0;
      else      req0 = 1'b0;
   endtask

   // Memory model: answer each accepted read command two cycles later
   initial begin : responder
      resp_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_en && sys_rst_n && app_en && app_rdy && app_cmd == 3'b001) begin
            repeat (2) @(posedge clk);
            #1 resp_valid = 1'b1;
            @(posedge clk);
            #1 resp_valid = 1'b0;
         end
      end
   end

   // Scoreboard monitor
   initial begin : monitor
      logic        prev_ack;
      logic [30:0] ec;
      logic [143:0] ew;
      logic [33:0] ea;
      prev_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!sys_rst_n) begin
            prev_ack = 1'b0;
         end else begin
            if (app_en && app_rdy) begin
               if (cmd_q.size() == 0) fail("cmd_unexpected");
               else begin
                  ec = cmd_q.pop_front();
                  chk("cmd_addr_op", {app_addr, app_cmd}, ec);
               end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
               if (wdf_q.size() == 0) fail("wdf_unexpected");
               else begin
                  ew = wdf_q.pop_front();
                  chk("wdf_data_mask", {app_wdf_data, app_wdf_mask}, ew);
                  chk("wdf_end", app_wdf_end, 1'b1);
               end
            end
            if (ack0 || ack1) begin
               if (ack_q.size() == 0) fail("ack_unexpected");
               else begin
                  ea = ack_q.pop_front();
                  chk("ack_port", {ack1, ack0}, ea[32] ? 2'b10 : 2'b01);
                  if (ea[33]) chk("rdata", rdata, ea[31:0]);
               end
               chk("ack_one_cycle", prev_ack, 1'b0);
            end
            prev_ack = ack0 | ack1;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin : stim
      int lat, lat2, w;
      sys_rst_n = 1'b1; init_calib_complete = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      stale_valid = 1'b0; resp_en = 1'b1;
      rd_line = {32'h12345678, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
      #2 sys_rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_app_en", app_en, 1'b0);
      chk("rst_wren", app_wdf_wren, 1'b0);
      chk("rst_acks", {ack1, ack0}, 2'b00);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_app_addr", app_addr, 28'h0);
      chk("rst_mask", app_wdf_mask, 16'hFFFF);
      chk("rst_wdf_data", app_wdf_data, 128'h0);
      sys_rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Single writes and reads at every word offset
      exp_wr(1'b0, 28'h8, 32'hDEADBEEF, 16'hFF0F);
      request(1'b0, 1'b1, 28'h14, 32'hDEADBEEF, lat);
      chk("wr_latency", lat, 3);
      exp_rd(1'b1, 28'h8, 32'h12345678);
      request(1'b1, 1'b0, 28'h1C, 32'h0, lat);
      exp_rd(1'b0, 28'h80, 32'hAAAA0000);
      request(1'b0, 1'b0, 28'h100, 32'h0, lat);
      exp_rd(1'b1, 28'h18, 32'hCCCC0002);
      request(1'b1, 1'b0, 28'h38, 32'h0, lat);
      exp_wr(1'b1, 28'h10, 32'h0BADF00D, 16'h0FFF);
      request(1'b1, 1'b1, 28'h2C, 32'h0BADF00D, lat);
      exp_wr(1'b0, 28'h20, 32'hCAFEF00D, 16'hFFF0);
      request(1'b0, 1'b1, 28'h40, 32'hCAFEF00D, lat);

      // Backpressure on both write handshakes
      app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      exp_wr(1'b0, 28'h28, 32'hA5A5A5A5, 16'hF0FF);
      fork
         request(1'b0, 1'b1, 28'h58, 32'hA5A5A5A5, lat);
         begin
            w = 0;
            do begin @(negedge clk); w++; end while (!app_en && w < 20);
            chk("bp_en_rise", app_en, 1'b1);
            for (int i = 1; i <= 8; i++) begin
               @(posedge clk); #1;
               if (i == 5) app_rdy = 1'b1;
               if (i == 8) app_wdf_rdy = 1'b1;
               @(negedge clk);
               chk("bp_app_en", app_en, (i <= 5));
               chk("bp_wren", app_wdf_wren, 1'b1);
               chk("bp_no_ack", ack0, 1'b0);
            end
            @(negedge clk);
            chk("bp_wren_drop", app_wdf_wren, 1'b0);
            chk("bp_ack_after_both", ack0, 1'b1);
         end
      join

      // Reset while waiting for read data, then a stale return
      resp_en = 1'b0;
      cmd_q.push_back({28'h8, 3'b001});
      @(posedge clk); #1;
      we1 = 1'b0; addr1 = 28'h1C; req1 = 1'b1;
      w = 0;
      do begin @(negedge clk); w++; end while (!(app_en && app_rdy) && w < 20);
      if (!(app_en && app_rdy)) fail("rd_cmd_timeout");
      @(posedge clk); #1;
      @(posedge clk); #1;
      sys_rst_n = 1'b0; req1 = 1'b0;
      #2;
      chk("async_rst_addr", app_addr, 28'h0);
      chk("async_rst_cmd", app_cmd, 3'b000);
      chk("async_rst_mask", app_wdf_mask, 16'hFFFF);
      chk("async_rst_wdf", app_wdf_data, 128'h0);
      @(posedge clk); #1 sys_rst_n = 1'b1;
      @(posedge clk); #1 stale_valid = 1'b1;
      @(posedge clk); #1 stale_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("stale_no_ack", {ack1, ack0}, 2'b00);
         chk("stale_no_en", app_en, 1'b0);
      end
      chk("stale_rdata", rdata, 32'h0);
      resp_en = 1'b1;
      exp_wr(1'b1, 28'h30, 32'h600DF00D, 16'hFFF0);
      request(1'b1, 1'b1, 28'h60, 32'h600DF00D, lat);
      chk("post_rst_latency", lat, 3);

      // No command while calibration is incomplete
      init_calib_complete = 1'b0;
      exp_wr(1'b0, 28'h18, 32'h5A5A5A5A, 16'hFFF0);
      fork
         request(1'b0, 1'b1, 28'h30, 32'h5A5A5A5A, lat);
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               chk("calib_no_en", app_en, 1'b0);
               chk("calib_no_ack", ack0, 1'b0);
            end
            @(posedge clk); #1 init_calib_complete = 1'b1;
         end
      join

      // Two ties straight after reset: grants go 0,1,0,1
      @(posedge clk); #1 sys_rst_n = 1'b0;
      @(posedge clk); #1 sys_rst_n = 1'b1;
      exp_wr(1'b0, 28'h0, 32'h11111111, 16'hFFF0);
      exp_wr(1'b1, 28'h10, 32'h22222222, 16'hFF0F);
      fork
         request(1'b0, 1'b1, 28'h0, 32'h11111111, lat);
         request(1'b1, 1'b1, 28'h24, 32'h22222222, lat2);
      join
      exp_wr(1'b0, 28'h18, 32'h33333333, 16'hF0FF);
      exp_wr(1'b1, 28'h20, 32'h44444444, 16'h0FFF);
      fork
         request(1'b0, 1'b1, 28'h38, 32'h33333333, lat);
         request(1'b1, 1'b1, 28'h4C, 32'h44444444, lat2);
      join

      repeat (3) @(negedge clk);
      chk("cmd_q_drained", cmd_q.size(), 0);
      chk("wdf_q_drained", wdf_q.size(), 0);
      chk("ack_q_drained", ack_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
